// File: rtl/result_streamer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | result_streamer_pkg : shared constants and FSM encoding               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package result_streamer_pkg;

   localparam logic [7:0] FRAME_SYNC = 8'hA5;
   localparam int         PROG_W_DEF = 9;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SYNC = 3'd1,
      PHI  = 3'd2,
      PLO  = 3'd3,
      BODY = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/result_streamer_byte_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | result_streamer_byte_serializer : MSB-first byte shifter for a word   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module result_streamer_byte_serializer #(
   parameter int MSG_W = 512
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             load_i,
   input  logic [MSG_W-1:0] word_i,
   input  logic             shift_i,
   output logic [7:0]       byte_o,
   output logic [7:0]       next_byte_o,
   output logic             last_o
);

   localparam int NBYTES = MSG_W / 8;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   logic [MSG_W-1:0] r_shift;
   logic [IDX_W-1:0] r_idx;

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         r_shift <= '0;
         r_idx   <= '0;
      end else if (load_i) begin
         r_shift <= word_i;
         r_idx   <= '0;
      end else if (shift_i) begin
         r_shift <= r_shift << 8;
         r_idx   <= r_idx + IDX_W'(1);
      end
   end

   assign byte_o = r_shift[MSG_W-1 -: 8];
   assign last_o = (r_idx == IDX_W'(NBYTES - 1));

   // The top registers tx_data, so it needs the byte that follows the current one.
   generate
      if (NBYTES > 1) begin : g_next_byte
         assign next_byte_o = r_shift[MSG_W-9 -: 8];
      end else begin : g_single_byte
         assign next_byte_o = 8'h00;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/result_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | result_streamer : snapshots progress improvements, streams as frames  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module result_streamer
   import result_streamer_pkg::*;
#(
   parameter int MSG_W    = 512,
   parameter int PROG_W   = PROG_W_DEF,
   parameter int MIN_PROG = 1
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic [PROG_W-1:0] progress_i,
   input  logic [MSG_W-1:0]  msg_i,
   output logic [7:0]        tx_data_o,
   output logic              tx_valid_o,
   input  logic              tx_ready_i,
   output logic              busy_o,
   output logic [15:0]       frames_o,
   output logic [15:0]       dropped_o
);

   state_t            r_state, w_state_nxt;
   logic [PROG_W-1:0] r_last_prog, r_pend_prog, r_cur_prog;
   logic [MSG_W-1:0]  r_pend_msg;
   logic              r_pend_v, r_tx_valid, r_busy;
   logic [7:0]        r_tx_data;
   logic [15:0]       r_frames, r_dropped;

   logic              w_capture, w_accept, w_load, w_pend_v_nxt;
   logic              w_shift, w_frame_done, w_tx_valid_nxt;
   logic [7:0]        w_tx_data_nxt, w_ser_byte, w_ser_next;
   logic              w_ser_last;
   logic [15:0]       w_prog16;

   assign w_capture    = (progress_i > r_last_prog) && (progress_i >= PROG_W'(MIN_PROG));
   assign w_accept     = r_tx_valid & tx_ready_i;
   assign w_load       = (r_state == IDLE) & r_pend_v;
   // A capture in the load cycle refills pend rather than being dropped.
   assign w_pend_v_nxt = w_capture | (r_pend_v & ~w_load);
   assign w_prog16     = 16'(r_cur_prog);

   result_streamer_byte_serializer #(.MSG_W(MSG_W)) u_byte_serializer (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .load_i      (w_load),
      .word_i      (r_pend_msg),
      .shift_i     (w_shift),
      .byte_o      (w_ser_byte),
      .next_byte_o (w_ser_next),
      .last_o      (w_ser_last)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_ni) r_state <= IDLE;
      else           r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (r_pend_v)                w_state_nxt = SYNC;
         SYNC:    if (w_accept)                w_state_nxt = PHI;
         PHI:     if (w_accept)                w_state_nxt = PLO;
         PLO:     if (w_accept)                w_state_nxt = BODY;
         BODY:    if (w_accept && w_ser_last)  w_state_nxt = IDLE;
         default:                              w_state_nxt = IDLE;
      endcase
   end

   // Produces the byte that will be on the bus after this edge.
   always_comb begin
      w_tx_data_nxt  = r_tx_data;
      w_tx_valid_nxt = r_tx_valid;
      w_shift        = 1'b0;
      w_frame_done   = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_tx_valid_nxt = r_pend_v;
            if (r_pend_v) w_tx_data_nxt = FRAME_SYNC;
         end
         SYNC: if (w_accept) w_tx_data_nxt = w_prog16[15:8];
         PHI:  if (w_accept) w_tx_data_nxt = w_prog16[7:0];
         PLO:  if (w_accept) w_tx_data_nxt = w_ser_byte;
         BODY: begin
            if (w_accept) begin
               if (w_ser_last) begin
                  w_tx_valid_nxt = 1'b0;
                  w_tx_data_nxt  = 8'h00;
                  w_frame_done   = 1'b1;
               end else begin
                  w_tx_data_nxt  = w_ser_next;
                  w_shift        = 1'b1;
               end
            end
         end
         default: begin
            w_tx_valid_nxt = 1'b0;
            w_tx_data_nxt  = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         r_last_prog <= '0;
         r_pend_prog <= '0;
         r_cur_prog  <= '0;
         r_pend_msg  <= '0;
         r_pend_v    <= 1'b0;
         r_tx_data   <= 8'h00;
         r_tx_valid  <= 1'b0;
         r_busy      <= 1'b0;
         r_frames    <= 16'h0000;
         r_dropped   <= 16'h0000;
      end else begin
         if (w_capture) begin
            r_pend_prog <= progress_i;
            r_pend_msg  <= msg_i;
            r_last_prog <= progress_i;
         end
         if (w_load) r_cur_prog <= r_pend_prog;
         if (w_capture && r_pend_v && !w_load && (r_dropped != 16'hFFFF))
            r_dropped <= r_dropped + 16'd1;
         if (w_frame_done) r_frames <= r_frames + 16'd1;
         r_pend_v   <= w_pend_v_nxt;
         r_tx_data  <= w_tx_data_nxt;
         r_tx_valid <= w_tx_valid_nxt;
         r_busy     <= (w_state_nxt != IDLE) | w_pend_v_nxt;
      end
   end

   assign tx_data_o  = r_tx_data;
   assign tx_valid_o = r_tx_valid;
   assign busy_o     = r_busy;
   assign frames_o   = r_frames;
   assign dropped_o  = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_result_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_result_streamer : directed self-checking bench for result_streamer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_result_streamer;

   localparam int MSG_W     = 512;
   localparam int PROG_W    = 9;
   localparam int NB        = MSG_W / 8;
   localparam int FRAME_LEN = NB + 3;

   logic              clk = 1'b0;
   logic              reset_ni = 1'b0;
   logic [PROG_W-1:0] progress_i = '0;
   logic [MSG_W-1:0]  msg_i = '0;
   logic              tx_ready_i = 1'b0;
   logic [7:0]        tx_data_o;
   logic              tx_valid_o;
   logic              busy_o;
   logic [15:0]       frames_o;
   logic [15:0]       dropped_o;

   int checks = 0;
   int errors = 0;

   result_streamer #(.MSG_W(MSG_W), .PROG_W(PROG_W), .MIN_PROG(1)) dut (
      .clk_i      (clk),
      .reset_ni   (reset_ni),
      .progress_i (progress_i),
      .msg_i      (msg_i),
      .tx_data_o  (tx_data_o),
      .tx_valid_o (tx_valid_o),
      .tx_ready_i (tx_ready_i),
      .busy_o     (busy_o),
      .frames_o   (frames_o),
      .dropped_o  (dropped_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [MSG_W-1:0] make_msg(input logic [7:0] seed, input logic [7:0] step);
      logic [MSG_W-1:0] m;
      m = '0;
      for (int i = 0; i < NB; i++) m[MSG_W-1-8*i -: 8] = seed + 8'(step * i);
      return m;
   endfunction

   // Collects one frame and compares every accepted byte; also checks hold while stalled.
   task automatic recv_frame(input logic [PROG_W-1:0] exp_prog, input logic [MSG_W-1:0] exp_msg,
                             input bit rand_ready, input string name,
                             output int first_cyc, output int span);
      logic [7:0] exp_b [FRAME_LEN];
      int         idx, cyc, last_cyc;
      bit         stalled;
      logic [7:0] held;
      exp_b[0] = 8'hA5;
      exp_b[1] = {7'b0, exp_prog[8]};
      exp_b[2] = exp_prog[7:0];
      for (int i = 0; i < NB; i++) exp_b[3+i] = exp_msg[MSG_W-1-8*i -: 8];
      idx = 0; cyc = 0; last_cyc = 0; stalled = 1'b0; held = 8'h00; first_cyc = -1;
      while (idx < FRAME_LEN && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (stalled) begin
            checks++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== held) begin
               errors++;
               $display("FAIL %s hold byte %0d: valid=%b data=%h, required valid=1 data=%h",
                        name, idx, tx_valid_o, tx_data_o, held);
            end
         end
         tx_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (tx_valid_o === 1'b1 && tx_ready_i) begin
            if (first_cyc < 0) first_cyc = cyc;
            checks++;
            if (tx_data_o !== exp_b[idx]) begin
               errors++;
               $display("FAIL %s byte %0d: got %h, required %h", name, idx, tx_data_o, exp_b[idx]);
            end
            idx++;
            last_cyc = cyc;
            stalled  = 1'b0;
         end else begin
            stalled = (tx_valid_o === 1'b1);
            held    = tx_data_o;
         end
      end
      span = last_cyc - first_cyc + 1;
      if (idx < FRAME_LEN) begin
         errors++;
         $display("FAIL %s timeout: %0d bytes received, required %0d", name, idx, FRAME_LEN);
      end
   endtask

   task automatic apply_reset();
      reset_ni   = 1'b0;
      progress_i = '0;
      repeat (3) @(negedge clk);
      reset_ni = 1'b1;
   endtask

   task automatic test_reset();
      reset_ni = 1'b0; progress_i = '0; tx_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_valid_o, busy_o, frames_o, dropped_o} !== 34'd0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b busy=%b frames=%0d dropped=%0d, required all 0",
                  tx_valid_o, busy_o, frames_o, dropped_o);
      end
      reset_ni = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: valid=%b busy=%b, required 0 0", tx_valid_o, busy_o);
         end
      end
   endtask

   task automatic test_first_frame();
      int f, s;
      progress_i = 9'd5; msg_i = make_msg(8'h00, 8'h01);
      @(negedge clk);
      checks++;
      if (tx_valid_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL capture_latency: valid=%b busy=%b, required valid=0 busy=1", tx_valid_o, busy_o);
      end
      recv_frame(9'd5, make_msg(8'h00, 8'h01), 1'b0, "ramp_frame", f, s);
      checks++;
      if (f != 1 || s != FRAME_LEN) begin
         errors++;
         $display("FAIL ramp_timing: first=%0d span=%0d, required first=1 span=%0d", f, s, FRAME_LEN);
      end
      @(negedge clk);
      checks++;
      if (frames_o !== 16'd1 || tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL ramp_done: frames=%0d valid=%b busy=%b, required 1 0 0", frames_o, tx_valid_o, busy_o);
      end
   endtask

   task automatic test_header_widths();
      int f, s;
      progress_i = 9'd160; msg_i = make_msg(8'h11, 8'h03);
      recv_frame(9'd160, make_msg(8'h11, 8'h03), 1'b0, "prog160", f, s);
      @(negedge clk);
      progress_i = 9'd256; msg_i = make_msg(8'hF0, 8'hFF);
      recv_frame(9'd256, make_msg(8'hF0, 8'hFF), 1'b0, "prog256", f, s);
      @(negedge clk);
      progress_i = 9'd100; msg_i = make_msg(8'h77, 8'h00);
      repeat (6) @(negedge clk);
      checks++;
      if (frames_o !== 16'd3 || tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL decrease_ignored: frames=%0d valid=%b busy=%b, required 3 0 0", frames_o, tx_valid_o, busy_o);
      end
   endtask

   task automatic test_coalesce();
      int f, s;
      apply_reset();
      tx_ready_i = 1'b0;
      progress_i = 9'd4; msg_i = make_msg(8'h40, 8'h01);
      repeat (2) @(negedge clk);
      checks++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hA5) begin
         errors++;
         $display("FAIL stall_sync: valid=%b data=%h, required 1 a5", tx_valid_o, tx_data_o);
      end
      progress_i = 9'd7;  msg_i = make_msg(8'h70, 8'h02); @(negedge clk);
      progress_i = 9'd9;  msg_i = make_msg(8'h90, 8'h03); @(negedge clk);
      progress_i = 9'd12; msg_i = make_msg(8'hC0, 8'h05); @(negedge clk);
      checks++;
      if (dropped_o !== 16'd2 || tx_valid_o !== 1'b1 || tx_data_o !== 8'hA5) begin
         errors++;
         $display("FAIL coalesce_drop: dropped=%0d valid=%b data=%h, required 2 1 a5", dropped_o, tx_valid_o, tx_data_o);
      end
      recv_frame(9'd4, make_msg(8'h40, 8'h01), 1'b0, "coalesce_cur", f, s);
      @(negedge clk);
      checks++;
      if (frames_o !== 16'd1 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL coalesce_pending: frames=%0d busy=%b, required 1 1", frames_o, busy_o);
      end
      recv_frame(9'd12, make_msg(8'hC0, 8'h05), 1'b0, "coalesce_new", f, s);
      @(negedge clk);
      checks++;
      if (frames_o !== 16'd2 || dropped_o !== 16'd2 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL coalesce_done: frames=%0d dropped=%0d busy=%b, required 2 2 0", frames_o, dropped_o, busy_o);
      end
   endtask

   task automatic test_random_ready();
      int f, s;
      progress_i = 9'd20; msg_i = make_msg(8'h5A, 8'h25);
      recv_frame(9'd20, make_msg(8'h5A, 8'h25), 1'b1, "random_ready", f, s);
      tx_ready_i = 1'b1;
      @(negedge clk);
      checks++;
      if (frames_o !== 16'd3) begin
         errors++;
         $display("FAIL random_count: frames=%0d, required 3", frames_o);
      end
   endtask

   task automatic test_back_to_back();
      int f, s;
      tx_ready_i = 1'b1;
      progress_i = 9'd30; msg_i = make_msg(8'h30, 8'h07);
      @(negedge clk);
      // Lands on the cycle that loads 30: refills pend without counting a drop.
      progress_i = 9'd40; msg_i = make_msg(8'hA0, 8'h0B);
      recv_frame(9'd30, make_msg(8'h30, 8'h07), 1'b0, "b2b_first", f, s);
      @(negedge clk);
      checks++;
      if (tx_valid_o !== 1'b0 || frames_o !== 16'd4 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap: valid=%b frames=%0d busy=%b, required 0 4 1", tx_valid_o, frames_o, busy_o);
      end
      recv_frame(9'd40, make_msg(8'hA0, 8'h0B), 1'b0, "b2b_second", f, s);
      checks++;
      if (f != 1 || s != FRAME_LEN || dropped_o !== 16'd2) begin
         errors++;
         $display("FAIL b2b_timing: first=%0d span=%0d dropped=%0d, required 1 %0d 2", f, s, dropped_o, FRAME_LEN);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midframe();
      int f, s, seen, cyc;
      logic [MSG_W-1:0] m;
      m = make_msg(8'h01, 8'h13);
      tx_ready_i = 1'b1;
      progress_i = 9'd50; msg_i = m;
      seen = 0; cyc = 0;
      while (seen < 23 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (tx_valid_o === 1'b1) seen++;
      end
      @(negedge clk);
      checks++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== m[MSG_W-1-8*20 -: 8]) begin
         errors++;
         $display("FAIL body20: valid=%b data=%h, required 1 %h", tx_valid_o, tx_data_o, m[MSG_W-1-8*20 -: 8]);
      end
      reset_ni = 1'b0; progress_i = '0;
      @(negedge clk);
      checks++;
      if ({tx_valid_o, busy_o, frames_o, dropped_o} !== 34'd0) begin
         errors++;
         $display("FAIL midframe_reset: valid=%b busy=%b frames=%0d dropped=%0d, required all 0",
                  tx_valid_o, busy_o, frames_o, dropped_o);
      end
      @(negedge clk);
      reset_ni = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (tx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL no_trailing: valid=%b, required 0", tx_valid_o);
         end
      end
      progress_i = 9'd3; msg_i = make_msg(8'hE0, 8'h09);
      recv_frame(9'd3, make_msg(8'hE0, 8'h09), 1'b0, "post_reset", f, s);
      @(negedge clk);
      checks++;
      if (frames_o !== 16'd1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_done: frames=%0d busy=%b, required 1 0", frames_o, busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_header_widths();
      test_coalesce();
      test_random_ready();
      test_back_to_back();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
